// File: rtl/histogram_stream_if.sv
// Stream bundle for histogram_stream: sample input, readout output and status.
// master drives samples and readout acceptance; slave is the histogram engine.
interface histogram_stream_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BIN_BITS = 4,
    parameter int unsigned CNT_W    = 8
);
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                dump_req;
    logic [CNT_W-1:0]    out_data;
    logic [BIN_BITS-1:0] out_bin;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                sat_flag;

    modport master (
        output in_data, in_valid, dump_req, out_ready,
        input  in_ready, out_data, out_bin, out_valid, out_last, sat_flag
    );

    modport slave (
        input  in_data, in_valid, dump_req, out_ready,
        output in_ready, out_data, out_bin, out_valid, out_last, sat_flag
    );
endinterface

// File: rtl/histogram_stream.sv
// Streaming histogram: bins samples by their MSBs into saturating counters, then
// streams every bin out under back-pressure, clearing each bin as it is read.
module histogram_stream #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BIN_BITS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WINDOW   = 0
) (
    input logic               clk,
    input logic               rst_n,
    histogram_stream_if.slave bus
);
    localparam int unsigned NUM_BINS = 2 ** BIN_BITS;
    localparam int unsigned WIN_W    = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;

    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [BIN_BITS-1:0] IDX_LAST = '1;
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'((WINDOW > 0) ? WINDOW - 1 : 0);

    typedef enum logic {StAccum, StDump} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q [NUM_BINS];
    logic [CNT_W-1:0]    count_d [NUM_BINS];
    logic [BIN_BITS-1:0] idx_q, idx_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic                sat_q, sat_d;
    logic [BIN_BITS-1:0] in_bin;

    assign in_bin = bus.in_data[DATA_W-1 -: BIN_BITS];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        win_d   = win_q;
        sat_d   = sat_q;

        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_bin   = idx_q;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.sat_flag  = sat_q;

        unique case (state_q)
            StAccum: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (count_q[in_bin] == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d[in_bin] = count_q[in_bin] + 1'b1;
                    end
                    if (WINDOW > 0) begin
                        if (win_q == WIN_LAST) begin
                            win_d   = '0;
                            state_d = StDump;
                        end else begin
                            win_d = win_q + 1'b1;
                        end
                    end
                end
                // A manual request and a window completion merge into one readout.
                if (bus.dump_req) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                bus.out_valid = 1'b1;
                bus.out_data  = count_q[idx_q];
                bus.out_last  = (idx_q == IDX_LAST);
                if (bus.out_ready) begin
                    count_d[idx_q] = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        sat_d   = 1'b0;
                        win_d   = '0;
                        state_d = StAccum;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            count_q <= '{default: '0};
            idx_q   <= '0;
            win_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            sat_q   <= sat_d;
        end
    end
endmodule

// File: tb/tb_histogram_stream.sv
// Bench for histogram_stream: a manual-only instance and a WINDOW=4 instance share
// one stimulus stream; a histogram model feeds expected beats to a negedge monitor.
module tb_histogram_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        dump_req = 1'b0;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    histogram_stream_if #(.DATA_W(16), .BIN_BITS(4), .CNT_W(8)) b0 ();
    histogram_stream_if #(.DATA_W(16), .BIN_BITS(4), .CNT_W(8)) b1 ();

    assign b0.in_data   = in_data;
    assign b0.in_valid  = in_valid;
    assign b0.dump_req  = dump_req;
    assign b0.out_ready = out_ready;
    assign b1.in_data   = in_data;
    assign b1.in_valid  = in_valid;
    assign b1.dump_req  = dump_req;
    assign b1.out_ready = out_ready;

    histogram_stream #(.DATA_W(16), .BIN_BITS(4), .CNT_W(8), .WINDOW(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    histogram_stream #(.DATA_W(16), .BIN_BITS(4), .CNT_W(8), .WINDOW(4)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    typedef struct {
        int bin;
        int cnt;
        bit last;
        bit sat;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int m_cnt   [2][16];
    bit m_dump  [2];
    int m_beats [2];
    int m_win   [2];
    bit m_sat   [2];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) m_cnt[i][k] = 0;
            m_dump[i]  = 1'b0;
            m_beats[i] = 0;
            m_win[i]   = 0;
            m_sat[i]   = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock of the histogram rules for instance i, from the driven inputs.
    task automatic model_step(input int i, input int window);
        bit trig;
        int b;
        beat_t e;
        if (!m_dump[i]) begin
            trig = dump_req;
            if (in_valid) begin
                b = int'(in_data[15:12]);
                if (m_cnt[i][b] == 255) m_sat[i] = 1'b1;
                else m_cnt[i][b]++;
                if (window > 0) begin
                    m_win[i]++;
                    if (m_win[i] == window) begin
                        m_win[i] = 0;
                        trig = 1'b1;
                    end
                end
            end
            if (trig) begin
                m_dump[i]  = 1'b1;
                m_beats[i] = 16;
                for (int k = 0; k < 16; k++) begin
                    e.bin  = k;
                    e.cnt  = m_cnt[i][k];
                    e.last = (k == 15);
                    e.sat  = m_sat[i];
                    if (i == 0) q0.push_back(e);
                    else q1.push_back(e);
                    m_cnt[i][k] = 0;
                end
            end
        end else if (out_ready) begin
            m_beats[i]--;
            if (m_beats[i] == 0) begin
                m_dump[i] = 1'b0;
                m_sat[i]  = 1'b0;
                m_win[i]  = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0, 0);
                model_step(1, 4);
            end
        end
    end

    task automatic mon(input int i, input logic ir, input logic ov, input logic [3:0] ob,
                       input logic [7:0] od, input logic ol, input logic sf);
        beat_t e;
        int    sz;
        chk($sformatf("u%0d in_ready", i), int'(ir), int'(!m_dump[i]));
        chk($sformatf("u%0d out_valid", i), int'(ov), int'(m_dump[i]));
        chk($sformatf("u%0d sat_flag", i), int'(sf), int'(m_sat[i]));
        if (m_dump[i]) begin
            sz = (i == 0) ? q0.size() : q1.size();
            chk($sformatf("u%0d beat available", i), int'(sz > 0), 1);
            if (sz > 0) begin
                e = (i == 0) ? q0[0] : q1[0];
                chk($sformatf("u%0d out_bin", i), int'(ob), e.bin);
                chk($sformatf("u%0d out_data bin %0d", i, e.bin), int'(od), e.cnt);
                chk($sformatf("u%0d out_last", i), int'(ol), int'(e.last));
                chk($sformatf("u%0d beat sat_flag", i), int'(sf), int'(e.sat));
                if (out_ready) begin
                    if (i == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end else begin
            chk($sformatf("u%0d out_last idle", i), int'(ol), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0, b0.in_ready, b0.out_valid, b0.out_bin, b0.out_data, b0.out_last,
                b0.sat_flag);
            mon(1, b1.in_ready, b1.out_valid, b1.out_bin, b1.out_data, b1.out_last,
                b1.sat_flag);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic send(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pulse_dump();
        dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " u0 in_ready"}, int'(b0.in_ready), 1);
        chk({tag, " u0 out_valid"}, int'(b0.out_valid), 0);
        chk({tag, " u0 out_last"}, int'(b0.out_last), 0);
        chk({tag, " u0 out_bin"}, int'(b0.out_bin), 0);
        chk({tag, " u0 out_data"}, int'(b0.out_data), 0);
        chk({tag, " u0 sat_flag"}, int'(b0.sat_flag), 0);
        chk({tag, " u1 in_ready"}, int'(b1.in_ready), 1);
        chk({tag, " u1 out_valid"}, int'(b1.out_valid), 0);
        chk({tag, " u1 out_data"}, int'(b1.out_data), 0);
    endtask

    logic [15:0] samples [4];
    bit          bp_pat  [4];

    initial begin
        samples[0] = 16'h0000;
        samples[1] = 16'h1FFF;
        samples[2] = 16'h1000;
        samples[3] = 16'hF123;
        bp_pat[0] = 1'b1;
        bp_pat[1] = 1'b0;
        bp_pat[2] = 1'b0;
        bp_pat[3] = 1'b1;

        #2;
        chk_reset_outputs("reset");
        run(2);
        #2 rst_n = 1'b1;
        cyc();

        // Directed sample set, then two manual dumps (second reads all zeros).
        for (int k = 0; k < 4; k++) begin
            in_data  = samples[k];
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        pulse_dump();
        run(6);
        pulse_dump();
        run(20);
        pulse_dump();
        run(20);

        // Back-pressure during a dump.
        for (int k = 0; k < 7; k++) send(16'($urandom));
        pulse_dump();
        for (int k = 0; k < 80; k++) begin
            out_ready = bp_pat[k % 4];
            cyc();
        end
        out_ready = 1'b1;
        run(20);

        // Saturation of bin 2.
        in_data  = 16'h2000;
        in_valid = 1'b1;
        run(300);
        in_valid = 1'b0;
        run(20);
        pulse_dump();
        run(20);

        // Sample accepted in the same cycle as dump_req, then a dropped request.
        in_data  = 16'h3000;
        in_valid = 1'b1;
        dump_req = 1'b1;
        cyc();
        in_valid = 1'b0;
        dump_req = 1'b0;
        run(3);
        pulse_dump();
        run(20);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            in_data   = 16'($urandom);
            in_valid  = ($urandom_range(0, 1) == 1);
            dump_req  = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        dump_req  = 1'b0;
        out_ready = 1'b1;
        run(40);

        // Asynchronous reset in the middle of a dump.
        for (int k = 0; k < 6; k++) send(16'($urandom));
        pulse_dump();
        run(5);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async reset");
        run(2);
        #2 rst_n = 1'b1;
        cyc();
        pulse_dump();
        run(20);

        chk("u0 expected beats drained", q0.size(), 0);
        chk("u1 expected beats drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
